fir_filter_param: RTL

FIR_FILTER_PARAM -- requirements
Module: fir_filter_param

---
 rtl/fir_pkg.sv | 16 +
 rtl/fir_out_sat.sv | 45 ++++
 rtl/fir_filter_param.sv | 97 +++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared defaults and width helpers for the parameterised FIR filter.
package fir_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_COEF_W = 8;
    localparam int DEF_TAPS   = 8;
    localparam int DEF_OUT_W  = 16;
    localparam int MIN_TAPS   = 2;
    localparam int MAX_TAPS   = 32;

    // Accumulator must hold TAPS full-width products without overflow.
    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

endpackage

// File: rtl/fir_out_sat.sv
// Combinational output stage: accumulator to output width, wrapping by default
// or clamping when FIR_FILTER_SAT_EN is defined.
module fir_out_sat #(
    parameter int ACC_W = 19,
    parameter int OUT_W = 16
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] y
);

    generate
        if (OUT_W > ACC_W) begin : g_extend
            assign y = {{(OUT_W-ACC_W){acc[ACC_W-1]}}, acc};
        end else begin : g_narrow
`ifdef FIR_FILTER_SAT_EN
            localparam logic signed [ACC_W-1:0] SAT_MAX =
                {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
            localparam logic signed [ACC_W-1:0] SAT_MIN =
                {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

            function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W-1:0] a);
                if (a > SAT_MAX) begin
                    return SAT_MAX[OUT_W-1:0];
                end else if (a < SAT_MIN) begin
                    return SAT_MIN[OUT_W-1:0];
                end
                return a[OUT_W-1:0];
            endfunction

            assign y = saturate(acc);
`else
            // High accumulator bits are intentionally discarded in wrap mode.
            logic unused_acc;
            assign unused_acc = ^acc;

            function automatic logic signed [OUT_W-1:0] wrap(input logic signed [ACC_W-1:0] a);
                return a[OUT_W-1:0];
            endfunction

            assign y = wrap(acc);
`endif
        end
    endgenerate

endmodule

// File: rtl/fir_filter_param.sv
// Direct-form FIR with writable coefficients and a two-register product/sum
// pipeline; define FIR_FILTER_SAT_EN for saturating output instead of wrap.
module fir_filter_param
    import fir_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int TAPS   = DEF_TAPS,
    parameter int OUT_W  = DEF_OUT_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       in_valid,
    input  logic signed [DATA_W-1:0]   x_in,
    input  logic                       coef_we,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic signed [COEF_W-1:0]   coef_data,
    output logic                       out_valid,
    output logic signed [OUT_W-1:0]    y_out
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = acc_width(DATA_W, COEF_W, TAPS);

    logic signed [DATA_W-1:0] tap_p0  [TAPS];
    logic signed [COEF_W-1:0] coef    [TAPS];
    logic signed [PROD_W-1:0] prod_p1 [TAPS];
    logic signed [ACC_W-1:0]  sum_p1;
    logic signed [ACC_W-1:0]  acc_p2;
    logic                     vld_p0;
    logic                     vld_p1;
    logic                     vld_p2;

    // Stage 0: delay line, shifted only on accepted samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) tap_p0[k] <= '0;
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= in_valid & ~clr;
            if (clr) begin
                for (int k = 0; k < TAPS; k++) tap_p0[k] <= '0;
            end else if (in_valid) begin
                tap_p0[0] <= x_in;
                for (int k = 1; k < TAPS; k++) tap_p0[k] <= tap_p0[k-1];
            end
        end
    end

    // Coefficient bank; clr leaves it untouched, reset restores identity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) coef[k] <= (k == 0) ? COEF_W'(1) : COEF_W'(0);
        end else if (coef_we && (int'(coef_addr) < TAPS)) begin
            coef[coef_addr] <= coef_data;
        end
    end

    // Stage 1: full-width products
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) prod_p1[k] <= '0;
            vld_p1 <= 1'b0;
        end else begin
            for (int k = 0; k < TAPS; k++) prod_p1[k] <= PROD_W'(tap_p0[k]) * PROD_W'(coef[k]);
            vld_p1 <= vld_p0 & ~clr;
        end
    end

    always_comb begin
        sum_p1 = '0;
        for (int k = 0; k < TAPS; k++) sum_p1 = sum_p1 + ACC_W'(prod_p1[k]);
    end

    // Stage 2: accumulator only loads on valid, so y_out holds between pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p2 <= '0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1 & ~clr;
            if (vld_p1 && !clr) acc_p2 <= sum_p1;
        end
    end

    assign out_valid = vld_p2;

    fir_out_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_out_sat (
        .acc (acc_p2),
        .y   (y_out)
    );

endmodule
